// File: rtl/cpu_run_mon_pkg.sv
// cpu_run_mon_pkg
//
// Definitions shared by the run monitor, its cycle counter and the CPU
// harness. It holds the run-sequencer state type and the default
// datapath widths, which the CPU uses as well.
package cpu_run_mon_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_DUMP  = 3'd3,
        ST_DONE  = 3'd4
    } run_state_t;

endpackage

// File: rtl/run_cycle_counter.sv
// run_cycle_counter
//
// Saturating CNT_W-bit up-counter. It has a loadable terminal value and
// reports when the count in progress is the last one before that terminal.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   clr_i        synchronous clear of the count (has priority over inc_i)
//   load_i       latch load_val_i as the terminal value
//   load_val_i   terminal value to latch
//   inc_i        advance the count by one (it holds at all-ones)
//   count_o      current count
//   term_match_o count_o + 1 equals the terminal value (the current cycle is the last one)
//   term_zero_o  the latched terminal value is zero
module run_cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             term_match_o,
    output logic             term_zero_o
);

    localparam logic [CNT_W:0] ONE_EXT = (CNT_W+1)'(1);

    logic [CNT_W-1:0] term_q;

    // Terminal latch and saturating count. A clear and a load usually
    // arrive together when a run starts.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_o <= '0;
            term_q  <= '0;
        end else begin
            if (load_i) begin
                term_q <= load_val_i;
            end
            if (clr_i) begin
                count_o <= '0;
            end else if (inc_i && (count_o != '1)) begin
                count_o <= count_o + CNT_W'(1);
            end
        end
    end

    // The comparison is one bit wider, so count_o + 1 cannot wrap into a
    // false match at all-ones.
    assign term_match_o = (({1'b0, count_o} + ONE_EXT) == {1'b0, term_q});
    assign term_zero_o  = (term_q == '0);

endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor
//
// This is the run controller and register-dump engine for the single-cycle CPU.
// Each run holds the CPU in reset for RST_CYCLES cycles and then lets it
// advance for the latched cycle budget. Next it freezes the CPU and streams
// register-file entries 0..NUM_REGS-1 out over a valid/ready port. It
// ends with a one-cycle done_o pulse.
//
// Build option:
//   CPU_RUN_MON_HALT_EN  when defined, halt_i in a RUN cycle ends RUN after
//                        that cycle, and that cycle is counted. When it is
//                        undefined, halt_i is ignored.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-low reset
//   start_i             begin a run (sampled only in IDLE)
//   cycle_limit_i       run budget, latched when start_i is accepted
//   halt_i              early-stop request from the CPU
//   cpu_rst_o           active-low CPU reset
//   cpu_run_o           CPU advance enable
//   rf_addr_o/rf_data_i register-file debug read port (combinational data)
//   dump_valid_o/dump_ready_i/dump_idx_o/dump_data_o  register dump stream
//   cycles_o            cycles executed in the last run
//   busy_o              high in any state except IDLE
//   done_o              one-cycle pulse at the end of the dump
module cpu_run_monitor
    import cpu_run_mon_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_REGS   = 12,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RST_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      cycle_limit_i,
    input  logic                  halt_i,
    output logic                  cpu_rst_o,
    output logic                  cpu_run_o,
    output logic [REG_ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0]     rf_data_i,
    output logic                  dump_valid_o,
    input  logic                  dump_ready_i,
    output logic [REG_ADDR_W-1:0] dump_idx_o,
    output logic [DATA_W-1:0]     dump_data_o,
    output logic [CNT_W-1:0]      cycles_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]      RST_TERM = CNT_W'(RST_CYCLES);

    run_state_t state_q, state_d;

    logic                  start_acc;
    logic                  beat_xfer;
    logic                  halt_hit;
    logic                  rst_done;
    logic                  run_done;
    logic                  run_limit_zero;
    logic [REG_ADDR_W-1:0] idx_q;
    logic [CNT_W-1:0]      rst_cnt_unused;
    logic                  rst_zero_unused;

    assign start_acc = (state_q == ST_IDLE) && start_i;
    assign beat_xfer = (state_q == ST_DUMP) && dump_ready_i;

`ifdef CPU_RUN_MON_HALT_EN
    assign halt_hit = halt_i;
`else
    logic halt_unused;
    assign halt_unused = halt_i;
    assign halt_hit    = 1'b0;
`endif

    // Counts the cycles the CPU is held in reset. The terminal value is
    // reloaded with the constant on every start, which keeps the two
    // counter instances symmetric.
    run_cycle_counter #(.CNT_W(CNT_W)) u_rst_counter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (start_acc),
        .load_i       (start_acc),
        .load_val_i   (RST_TERM),
        .inc_i        (state_q == ST_RESET),
        .count_o      (rst_cnt_unused),
        .term_match_o (rst_done),
        .term_zero_o  (rst_zero_unused)
    );

    // Counts the cycles the CPU executes. Its count is cycles_o directly,
    // so the value holds from the end of RUN until the next accepted start.
    run_cycle_counter #(.CNT_W(CNT_W)) u_run_counter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (start_acc),
        .load_i       (start_acc),
        .load_val_i   (cycle_limit_i),
        .inc_i        (state_q == ST_RUN),
        .count_o      (cycles_o),
        .term_match_o (run_done),
        .term_zero_o  (run_limit_zero)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs. The CPU stays out of
    // reset from RUN to DONE, so the dump reads a frozen register file
    // and does not clear it.
    always_comb begin
        state_d      = state_q;
        cpu_rst_o    = 1'b1;
        cpu_run_o    = 1'b0;
        dump_valid_o = 1'b0;
        done_o       = 1'b0;
        busy_o       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                cpu_rst_o = 1'b0;
                busy_o    = 1'b0;
                if (start_i) begin
                    state_d = ST_RESET;
                end
            end
            ST_RESET: begin
                cpu_rst_o = 1'b0;
                if (rst_done) begin
                    state_d = run_limit_zero ? ST_DUMP : ST_RUN;
                end
            end
            ST_RUN: begin
                cpu_run_o = 1'b1;
                if (run_done || halt_hit) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                dump_valid_o = 1'b1;
                if (dump_ready_i && (idx_q == LAST_IDX)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                cpu_rst_o = 1'b0;
                busy_o    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Dump index. It advances only on a completed beat, so the index and
    // data hold through back-pressure. It returns to 0 outside DUMP.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q <= '0;
        end else if (beat_xfer) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + REG_ADDR_W'(1);
        end else if (state_q != ST_DUMP) begin
            idx_q <= '0;
        end
    end

    assign rf_addr_o   = idx_q;
    assign dump_idx_o  = idx_q;
    assign dump_data_o = rf_data_i;

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

- Synthesisable run controller and register-dump engine that wraps the single-cycle CPU for self-checking simulation and FPGA bring-up.
- Sequence per run:
  - hold the CPU in reset for a programmable number of cycles;
  - let it execute for a run-time cycle budget;
  - freeze it;
  - stream a parametrised number of register-file entries out over a valid/ready port.
- Sits between the top-level harness and the CPU's reset, run-enable and register-file debug read port.

## Interface
Parameters:
- DATA_W, 32, register-file data width
- REG_ADDR_W, 5, register-file address width
- NUM_REGS, 12, entries dumped (indices 0..NUM_REGS-1); 1 ≤ NUM_REGS ≤ 2^REG_ADDR_W
- CNT_W, 16, cycle counter / limit width
- RST_CYCLES, 1, cycles the CPU reset is held low per run (≥1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  begin a run; sampled only in IDLE
- cycle_limit_i  in  CNT_W  run budget in cycles; latched when start_i is accepted
- halt_i  in  1  early-stop request from the CPU (used only with the halt macro)
- cpu_rst_o  out  1  active-low reset to the CPU
- cpu_run_o  out  1  CPU clock-enable/advance
- rf_addr_o  out  REG_ADDR_W  register-file debug read address
- rf_data_i  in  DATA_W  combinational read data for rf_addr_o
- dump_valid_o  out  1  dump beat valid
- dump_ready_i  in  1  sink ready
- dump_idx_o  out  REG_ADDR_W  index of the current beat
- dump_data_o  out  DATA_W  data of the current beat
- cycles_o  out  CNT_W  cycles actually executed in the last run
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at end of dump

## Operation
States: IDLE, RESET, RUN, DUMP, DONE.

- **IDLE**
  - Outputs: cpu_rst_o=0, cpu_run_o=0.
  - On start_i=1: latch cycle_limit_i, clear cycles_o and the reset counter, go to RESET.
- **RESET**
  - Outputs: cpu_rst_o=0.
  - Stay RST_CYCLES cycles.
  - Then go to RUN, or directly to DUMP if the latched limit is 0.
- **RUN**
  - Outputs: cpu_rst_o=1, cpu_run_o=1.
  - cycles_o increments every RUN cycle.
  - Go to DUMP on the cycle in which cycles_o+1 equals the limit. The limit is exact: the CPU advances exactly `limit` times.
- **DUMP**
  - Outputs: cpu_rst_o=1, cpu_run_o=0, so the register file is frozen and not cleared.
  - Index counter starts at 0.
  - dump_valid_o=1, dump_idx_o=rf_addr_o=index, dump_data_o=rf_data_i.
  - A beat transfers when valid && ready; the index then increments.
  - The transfer of index NUM_REGS-1 moves to DONE.
- **DONE**
  - Outputs: done_o=1 for this single cycle, cpu_rst_o=1, cpu_run_o=0.
  - Next state is IDLE.
- Arithmetic: counters are unsigned.
- cycles_o saturates at 2^CNT_W-1; this cannot occur before the limit is reached.

## Timing
- Reset values (rst_i low, asynchronous): state IDLE, cpu_rst_o=0, cpu_run_o=0, dump_valid_o=0, done_o=0, busy_o=0, cycles_o=0, rf_addr_o=0, dump_idx_o=0, dump_data_o passes rf_data_i.
- Reset mid-run or mid-dump aborts immediately. No done_o pulse is produced.
- Latency from start_i accepted to the first cpu_run_o=1: RST_CYCLES+1 cycles.
- Handshake rules:
  - dump_valid_o never drops without a transfer.
  - idx and data are stable while valid && !ready (CPU frozen).
  - With ready held high, NUM_REGS beats take NUM_REGS consecutive cycles.
- start_i is ignored while busy_o=1.
- start_i in the DONE cycle is ignored; it is accepted on the following IDLE cycle.
- cycles_o holds its value from the end of RUN until the next accepted start.

## Configuration
- CPU_RUN_MON_HALT_EN defined:
  - halt_i=1 in a RUN cycle ends RUN after that cycle. That cycle is counted in cycles_o.
  - The dump then proceeds as normal.
  - If halt coincides with the limit being reached, the result is the same single transition to DUMP.
- Undefined: halt_i is ignored; RUN always lasts exactly the latched limit.

## Structure
- Shared package cpu_run_mon_pkg holds:
  - the state enum (IDLE, RESET, RUN, DUMP, DONE);
  - default DATA_W/REG_ADDR_W/CNT_W constants shared with the CPU.
- One sub-module: run_cycle_counter, a loadable, clearable, saturating CNT_W up-counter with a terminal-match output, instantiated for both RESET and RUN counting.
- The FSM and dump sequencer stay in the top module.

## Test plan
- rst_i low then high; start_i with limit=5, NUM_REGS=12, ready=1:
  - RESET lasts 1 cycle, cpu_run_o high exactly 5 cycles;
  - 12 beats with idx 0..11 on consecutive cycles;
  - done_o one cycle; cycles_o=5.
- limit=0: RESET then straight to DUMP; cpu_run_o never high; cycles_o=0.
- Backpressure: ready toggles 1,0,0,1 during the dump. idx/data are held through the stall and no beat is skipped or repeated (12 transfers total).
- rst_i asserted low during DUMP at idx 4: next cycle IDLE, dump_valid_o=0, cpu_rst_o=0, no done_o. A fresh start completes normally.
- With CPU_RUN_MON_HALT_EN, limit=100, halt_i pulsed on the 7th RUN cycle: cycles_o=7, dump follows. Without the macro the same stimulus gives cycles_o=100.
- start_i held high through the whole run: no restart while busy; a second run begins on the first IDLE cycle after DONE.
